// File: rtl/alu_sequencer.sv
// alu_sequencer: Moore control sequencer for a single-bus CPU datapath.
// Fetches one instruction (T0..T2, plus optional memory wait states in TW),
// then runs the operand/ALU/writeback micro-steps (T3..T6) and pulses done.
// Optional feature macro: ALU_SEQUENCER_HILO_EN enables the long-op path
// (ir[31]=1 writes LO in T5 and HI in T6). Without it a long op raises a
// one-cycle err in T5 and goes straight to DONE.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC -> MAR, increment PC into Z
// T1    | Zlow -> PC, start memory read into MDR
// TW    | hold memory read for MEM_WAIT extra cycles
// T2    | MDR -> IR
// T3    | Rb -> Y
// T4    | Rc through ALU -> Z
// T5    | Zlow -> Ra (short op) or Zlow -> LO (long op)
// T6    | Zhigh -> HI (long op only)
// DONE  | one-cycle completion pulse

module alu_sequencer #(
    parameter int MEM_WAIT = 0
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] ir,
    output logic [4:0]  BusDataSelect,
    output logic [3:0]  GP_addr,
    output logic        e_PC,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_HI,
    output logic        e_LO,
    output logic        e_MDR,
    output logic        e_MAR,
    output logic        e_GP,
    output logic        incPC,
    output logic        MDR_read,
    output logic [3:0]  ALU_op,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_TW, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
    } state_t;

    localparam logic [4:0] BUS_ZHIGH = 5'b10010;
    localparam logic [4:0] BUS_ZLOW  = 5'b10011;
    localparam logic [4:0] BUS_PC    = 5'b10100;
    localparam logic [4:0] BUS_MDR   = 5'b10101;
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_wait_cnt;

    logic       w_long;
    logic [3:0] w_ra;
    logic [3:0] w_rb;
    logic [3:0] w_rc;
    logic [3:0] w_alu;
    logic       w_unused_ir;

    assign w_long      = ir[31];
    assign w_alu       = ir[30:27];
    assign w_ra        = ir[26:23];
    assign w_rb        = ir[22:19];
    assign w_rc        = ir[18:15];
    assign w_unused_ir = ^ir[14:0];

    // State register; clear drops straight back to IDLE.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Wait-state down-counter: loaded in T1, counts down through TW.
    always_ff @(posedge clock or posedge clear) begin
        if (clear)                                    r_wait_cnt <= 4'd0;
        else if (r_state == S_T1)                     r_wait_cnt <= WAIT_LOAD;
        else if (r_state == S_TW && r_wait_cnt != 0)  r_wait_cnt <= r_wait_cnt - 4'd1;
    end

    // Next-state and Moore output decode from current state and ir.
    always_comb begin
        w_next        = r_state;
        BusDataSelect = 5'b00000;
        GP_addr       = 4'd0;
        e_PC          = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_HI          = 1'b0;
        e_LO          = 1'b0;
        e_MDR         = 1'b0;
        e_MAR         = 1'b0;
        e_GP          = 1'b0;
        incPC         = 1'b0;
        MDR_read      = 1'b0;
        ALU_op        = 4'd0;
        busy          = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_T0;
            end
            S_T0: begin
                busy          = 1'b1;
                BusDataSelect = BUS_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
                e_Z           = 1'b1;
                w_next        = S_T1;
            end
            S_T1: begin
                busy          = 1'b1;
                BusDataSelect = BUS_ZLOW;
                e_PC          = 1'b1;
                MDR_read      = 1'b1;
                e_MDR         = 1'b1;
                w_next        = (MEM_WAIT > 0) ? S_TW : S_T2;
            end
            S_TW: begin
                busy          = 1'b1;
                BusDataSelect = BUS_ZLOW;
                MDR_read      = 1'b1;
                e_MDR         = 1'b1;
                // Terminal count at 1: the last wait cycle is the one that sees 1.
                if (r_wait_cnt <= 4'd1) w_next = S_T2;
            end
            S_T2: begin
                busy          = 1'b1;
                BusDataSelect = BUS_MDR;
                e_IR          = 1'b1;
                w_next        = S_T3;
            end
            S_T3: begin
                busy          = 1'b1;
                BusDataSelect = {1'b0, w_rb};
                e_Y           = 1'b1;
                w_next        = S_T4;
            end
            S_T4: begin
                busy          = 1'b1;
                BusDataSelect = {1'b0, w_rc};
                ALU_op        = w_alu;
                e_Z           = 1'b1;
                w_next        = S_T5;
            end
            S_T5: begin
                busy = 1'b1;
                if (!w_long) begin
                    BusDataSelect = BUS_ZLOW;
                    GP_addr       = w_ra;
                    e_GP          = 1'b1;
                    w_next        = S_DONE;
                end else begin
`ifdef ALU_SEQUENCER_HILO_EN
                    BusDataSelect = BUS_ZLOW;
                    e_LO          = 1'b1;
                    w_next        = S_T6;
`else
                    // Long ops unsupported in this build: flag and finish.
                    err           = 1'b1;
                    w_next        = S_DONE;
`endif
                end
            end
            S_T6: begin
`ifdef ALU_SEQUENCER_HILO_EN
                busy          = 1'b1;
                BusDataSelect = BUS_ZHIGH;
                e_HI          = 1'b1;
                w_next        = S_DONE;
`else
                w_next        = S_IDLE;
`endif
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter MEM_WAIT, default 0, range 0..15: extra cycles T1 holds the memory read before T2.
REQ-002 SHALL have ports: clock  in  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: clear  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: start  in  1  begin one instruction; ir  in  32  datapath IR contents (op=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15]).
REQ-005 SHALL have outputs: BusDataSelect  out  5  bus source (5'b0rrrr=Rr, 10000 HI, 10001 LO, 10010 Zhigh, 10011 Zlow, 10100 PC, 10101 MDR); GP_addr  out  4  register-file write address.
REQ-006 SHALL have outputs, 1 bit each, load enables: e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP; plus incPC, MDR_read.
REQ-007 SHALL have outputs: ALU_op  out  4  ALU operation; busy  out  1  sequence in progress; done  out  1  one-cycle completion pulse; err  out  1  one-cycle illegal-op pulse.

Function
REQ-008 SHALL be a Moore FSM, states IDLE, T0, T1, TW, T2, T3, T4, T5, T6, DONE; all outputs decoded from current state and ir only.
REQ-009 SHALL leave IDLE for T0 on the edge start=1 is sampled; start outside IDLE is ignored, with no queuing.
REQ-010 T0: BusDataSelect=10100, e_MAR=1, incPC=1, e_Z=1.
REQ-011 T1: BusDataSelect=10011, e_PC=1, MDR_read=1, e_MDR=1; to TW if MEM_WAIT>0, else T2.
REQ-012 TW: MDR_read=1, e_MDR=1, BusDataSelect=10011, all other enables 0; stays exactly MEM_WAIT cycles using a 4-bit down-counter loaded in T1, then T2.
REQ-013 T2: BusDataSelect=10101, e_IR=1; ir is valid and stable from T3 until DONE.
REQ-014 T3: BusDataSelect={1'b0,Rb}, e_Y=1.
REQ-015 T4: BusDataSelect={1'b0,Rc}, ALU_op=ir[30:27], e_Z=1.
REQ-016 T5 short op (ir[31]=0): BusDataSelect=10011, GP_addr=Ra, e_GP=1; then DONE.
REQ-017 T5 long op (ir[31]=1): BusDataSelect=10011, e_LO=1; then T6: BusDataSelect=10010, e_HI=1; then DONE.
REQ-018 DONE: done=1 for one cycle, then IDLE unconditionally; start in DONE is ignored.
REQ-019 busy=1 in T0..T6 inclusive, 0 in IDLE and DONE.
REQ-020 Any enable not listed for a state SHALL be 0; ALU_op=0 outside T4; GP_addr=0 outside T5; BusDataSelect=00000 in IDLE/DONE.
REQ-021 Latency start-to-done, short op: 7+MEM_WAIT cycles; long op: 8+MEM_WAIT.

Reset
REQ-022 clear=1 SHALL force state IDLE, wait counter 0, and every output 0 immediately, regardless of clock and mid-sequence position.
REQ-023 After clear deasserts, the first start SHALL begin a clean T0; no partial sequence resumes.

Configuration
REQ-024 Macro ALU_SEQUENCER_HILO_EN: when defined, long-op path per REQ-017.
REQ-025 Without ALU_SEQUENCER_HILO_EN: in T5 with ir[31]=1, no enable asserts, err=1 for that cycle, next state DONE; T6 unreachable; short ops unchanged.

Verification
REQ-026 MEM_WAIT=0, ir=32'h2A338000 (op 00101, Ra=4, Rb=6, Rc=7), start pulse -> T3 bus 00110 e_Y, T4 bus 00111 ALU_op=0101 e_Z, T5 GP_addr=4 e_GP, done 7 cycles after start.
REQ-027 MEM_WAIT=3, same ir -> MDR_read/e_MDR high 4 consecutive cycles, done 10 cycles after start.
REQ-028 HILO_EN defined, ir=32'h7A338000 (ir[31]=0? no: use 32'hFA338000) -> T5 bus 10011 e_LO, T6 bus 10010 e_HI, e_GP never 1, done 8 cycles after start.
REQ-029 HILO_EN undefined, ir=32'hFA338000 -> err=1 in T5 cycle, no e_LO/e_HI/e_GP, done next cycle.
REQ-030 clear asserted mid-T3 between edges -> all outputs 0 same instant, busy=0; restart completes normally with done after 7 cycles.
REQ-031 start held high through a full sequence -> second sequence starts only from IDLE, one cycle after DONE; no start taken in DONE.
